// File: rtl/char_ram_arbiter.sv
// Shares the single-port character RAM between the per-cell video fetch and a host
// read/write port; video owns one fixed slot per 8-pixel cell while display_on.
module char_ram_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COL_BITS = 5,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned VID_SLOT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         display_on,
  input  logic [8:0]                   hpos,
  input  logic [8:0]                   vpos,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [ROW_BITS+COL_BITS-1:0] host_addr,
  input  logic [DATA_W-1:0]            host_wdata,
  output logic                         host_ready,
  output logic                         host_ack,
  output logic [DATA_W-1:0]            host_rdata,
  output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
  output logic [DATA_W-1:0]            ram_din,
  output logic                         ram_we,
  input  logic [DATA_W-1:0]            ram_dout,
  output logic [DATA_W-1:0]            vid_char
);

  localparam int unsigned AddrW = ROW_BITS + COL_BITS;

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [AddrW-1:0]    addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   vid_next_q;

  logic                vslot;
  logic                cap_phase;
  logic                load_phase;
  logic [COL_BITS-1:0] col_next;
  logic [AddrW-1:0]    vid_addr;

  assign vslot      = display_on && (hpos[2:0] == 3'(VID_SLOT));
  assign cap_phase  = (hpos[2:0] == 3'(VID_SLOT + 1));
  assign load_phase = (hpos[2:0] == 3'd7);

  // Prefetch the next cell's code; the column index wraps within the same row.
  assign col_next = hpos[COL_BITS+2:3] + COL_BITS'(1);
  assign vid_addr = {vpos[ROW_BITS+2:3], col_next};

  always_comb begin
    state_d    = state_q;
    ram_addr   = vid_addr;
    ram_din    = wdata_q;
    ram_we     = 1'b0;
    host_ready = 1'b0;
    host_ack   = 1'b0;
    unique case (state_q)
      StIdle: begin
        host_ready = 1'b1;
        if (host_req) state_d = StAccess;
      end
      StAccess: begin
        // A video slot always wins; the host simply retries next cycle.
        if (!vslot) begin
          ram_addr = addr_q;
          ram_we   = we_q;
          state_d  = we_q ? StDone : StCapture;
        end
      end
      StCapture: state_d = StDone;
      StDone: begin
        host_ack = 1'b1;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      host_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && host_req) begin
        addr_q  <= host_addr;
        we_q    <= host_we;
        wdata_q <= host_wdata;
      end
      if (state_q == StCapture) host_rdata <= ram_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_next_q <= '0;
      vid_char   <= '0;
    end else begin
      if (cap_phase)  vid_next_q <= ram_dout;
      if (load_phase) vid_char   <= vid_next_q;
    end
  end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Bench for char_ram_arbiter: behavioural RAM, directed vector table, reset corner cases
// and a randomized run against a transaction-level reference model.
module tb_char_ram_arbiter;

  localparam int unsigned VidSlot = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       display_on;
  logic [8:0] hpos, vpos;
  logic       host_req, host_we;
  logic [9:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ready, host_ack;
  logic [7:0] host_rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic [7:0] vid_char;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  char_ram_arbiter #(
    .DATA_W  (8),
    .COL_BITS(5),
    .ROW_BITS(5),
    .VID_SLOT(VidSlot)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .display_on(display_on),
    .hpos      (hpos),
    .vpos      (vpos),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ready(host_ready),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .vid_char  (vid_char)
  );

  // Synchronous RAM: registered read of the pre-write contents.
  logic [7:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
    forever begin
      @(posedge clk);
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  // Reference model state: one outstanding transaction plus shadow memory.
  logic [7:0] shadow [1024];
  logic       pend;
  logic       p_we;
  logic [9:0] p_addr;
  logic [7:0] p_data;
  logic [7:0] p_rval;
  int         p_acc, p_grant, cyc;
  logic [7:0] rdata_m, vid_next_m, vid_char_m, model_dout;
  logic       ack_s, we_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic       vs, grant_now, exp_we, exp_ack;
    logic [9:0] va, exp_addr;
    logic [7:0] nxt_dout;
    logic [4:0] col;
    @(negedge clk);
    col = hpos[7:3] + 5'd1;
    va  = {vpos[7:3], col};
    vs  = display_on && (hpos[2:0] == 3'(VidSlot));
    if (reset) begin
      chk("rst_ready", 32'(host_ready), 32'd1);
      chk("rst_ack", 32'(host_ack), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_rdata", 32'(host_rdata), 32'd0);
      chk("rst_vid_char", 32'(vid_char), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'(va));
      pend = 1'b0; rdata_m = 8'h00; vid_next_m = 8'h00; vid_char_m = 8'h00;
      ack_s = host_ack; we_s = ram_we;
      nxt_dout = shadow[va];
    end else begin
      // First non-video cycle after acceptance is the granted access.
      if (pend && p_grant < 0 && cyc > p_acc && !vs) p_grant = cyc;
      grant_now = pend && (p_grant == cyc);
      exp_we    = grant_now && p_we;
      exp_addr  = grant_now ? p_addr : va;
      exp_ack   = pend && p_grant >= 0 && (cyc == p_grant + (p_we ? 1 : 2));
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) chk("ram_din", 32'(ram_din), 32'(p_data));
      chk("host_ack", 32'(host_ack), 32'(exp_ack));
      chk("host_ready", 32'(host_ready), 32'(!pend));
      chk("host_rdata", 32'(host_rdata), 32'(rdata_m));
      chk("vid_char", 32'(vid_char), 32'(vid_char_m));
      ack_s = host_ack; we_s = ram_we;
      nxt_dout = shadow[exp_addr];
      if (grant_now && !p_we) p_rval = shadow[p_addr];
      if (pend && !p_we && p_grant >= 0 && cyc == p_grant + 1) rdata_m = p_rval;
      if (exp_we) shadow[p_addr] = p_data;
      if (hpos[2:0] == 3'd7) vid_char_m = vid_next_m;
      if (hpos[2:0] == 3'(VidSlot + 1)) vid_next_m = model_dout;
      if (exp_ack) pend = 1'b0;
      else if (!pend && host_req) begin
        pend = 1'b1; p_we = host_we; p_addr = host_addr; p_data = host_wdata;
        p_acc = cyc; p_grant = -1;
      end
    end
    model_dout = nxt_dout;
    @(posedge clk);
    #1;
    cyc++;
    hpos = hpos + 9'd1;
    if (hpos == 9'd0) vpos = vpos + 9'd1;
  endtask

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic       disp;
    logic [8:0] hstart;
    int         lat;
    logic [7:0] rdata;
  } vec_t;

  task automatic apply_vec(input string name, input vec_t v);
    int   lat, we_cnt;
    logic done;
    hpos = v.hstart; display_on = v.disp;
    host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    tick();
    we_cnt = 32'(we_s);
    host_req = 1'b0;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      lat++;
      we_cnt += 32'(we_s);
      if (ack_s) done = 1'b1;
    end
    chk({name, "_latency"}, 32'(lat), 32'(v.lat));
    chk({name, "_we_pulses"}, 32'(we_cnt), v.we ? 32'd1 : 32'd0);
    if (!v.we) chk({name, "_rdata"}, 32'(host_rdata), 32'(v.rdata));
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = '{we: 1'b1, addr: 10'h123, wdata: 8'h5A, disp: 1'b0, hstart: 9'h010, lat: 2, rdata: 8'h00};
    vecs[1] = '{we: 1'b0, addr: 10'h123, wdata: 8'h00, disp: 1'b0, hstart: 9'h010, lat: 3, rdata: 8'h5A};
    vecs[2] = '{we: 1'b1, addr: 10'h0A5, wdata: 8'h07, disp: 1'b0, hstart: 9'h000, lat: 2, rdata: 8'h00};
    vecs[3] = '{we: 1'b1, addr: 10'h3FF, wdata: 8'hA3, disp: 1'b1, hstart: 9'h007, lat: 3, rdata: 8'h00};
    vecs[4] = '{we: 1'b0, addr: 10'h3FF, wdata: 8'h00, disp: 1'b1, hstart: 9'h007, lat: 4, rdata: 8'hA3};
    vecs[5] = '{we: 1'b0, addr: 10'h0A5, wdata: 8'h00, disp: 1'b1, hstart: 9'h002, lat: 3, rdata: 8'h07};

    for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0; p_rval = '0;
    p_acc = 0; p_grant = -1; cyc = 0;
    rdata_m = '0; vid_next_m = '0; vid_char_m = '0; model_dout = '0;
    ack_s = 1'b0; we_s = 1'b0;

    reset = 1'b1; display_on = 1'b0; hpos = '0; vpos = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Video fetch of cell 5 in row 5, then code delivered at the next cell boundary.
    display_on = 1'b1; vpos = 9'h028; hpos = 9'h020;
    #1;
    chk("vid_fetch_addr", 32'(ram_addr), 32'h0A5);
    for (int i = 0; i < 8; i++) tick();
    chk("vid_char_cell", 32'(vid_char), 32'h07);

    hpos = 9'h0F8;
    #1;
    chk("vid_col_wrap", 32'(ram_addr), 32'h0A0);
    tick();

    // Reset during the ACCESS cycle of a write: write must be dropped.
    display_on = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h0A5; host_wdata = 8'hEE;
    tick();
    host_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstacc_we", 32'(ram_we), 32'd0);
    chk("rstacc_ack", 32'(host_ack), 32'd0);
    chk("rstacc_vid_char", 32'(vid_char), 32'd0);
    tick();
    reset = 1'b0;
    rv = '{we: 1'b0, addr: 10'h0A5, wdata: 8'h00, disp: 1'b0, hstart: 9'h001, lat: 3, rdata: 8'h07};
    apply_vec("after_rst_acc", rv);

    // Reset during CAPTURE of a read.
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h123; display_on = 1'b0;
    tick();
    host_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rstcap_rdata", 32'(host_rdata), 32'd0);
    chk("rstcap_ack", 32'(host_ack), 32'd0);
    chk("rstcap_ready", 32'(host_ready), 32'd1);
    tick();
    reset = 1'b0;
    rv = '{we: 1'b0, addr: 10'h123, wdata: 8'h00, disp: 1'b0, hstart: 9'h003, lat: 3, rdata: 8'h5A};
    apply_vec("after_rst_cap", rv);

    // Randomized traffic with the video fetch running and occasional async resets.
    for (int n = 0; n < 4000; n++) begin
      if (hpos[5:0] == 6'd0) display_on = ($urandom_range(0, 3) != 0);
      host_req   = ($urandom_range(0, 1) == 1);
      host_we    = ($urandom_range(0, 1) == 1);
      host_addr  = {3'b000, 2'($urandom_range(0, 3)), 3'b101, 2'($urandom_range(0, 3))};
      host_wdata = 8'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
